// File: rtl/im_loader.sv
// Boot-time instruction memory loader: unpacks a framed byte stream into
// 34-bit words and writes them at consecutive IM node addresses.
// Optional trailing checksum byte when IM_LOADER_CKSUM_EN is defined.
// AW must lie in 9..16 (the address comes from two header bytes).
module im_loader #(
    parameter int         AW  = 14,
    parameter logic [7:0] HDR = 8'hA5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    rx_data_i_iml,
    input  logic          rx_valid_i_iml,
    output logic          rx_ready_o_iml,
    output logic [AW-1:0] node_o_iml,
    output logic [31:0]   opr0_o_iml,
    output logic [1:0]    tf_uni_opr_o_iml,
    output logic [1:0]    mem_wen_o_iml,
    output logic          busy_o_iml,
    output logic          done_o_iml,
    output logic          err_o_iml
);

`ifdef IM_LOADER_CKSUM_EN
    typedef enum logic [3:0] {IDLE, A_H, A_L, C_H, C_L, DATA, WRITE, CKS, DONE} state_t;
    localparam state_t END_ST = CKS;
`else
    typedef enum logic [3:0] {IDLE, A_H, A_L, C_H, C_L, DATA, WRITE, DONE} state_t;
    localparam state_t END_ST = DONE;
`endif

    state_t        state_q, state_d;
    logic [AW-1:0] node_q, node_d;
    logic [31:0]   opr0_q, opr0_d;
    logic [1:0]    tf_q, tf_d;
    logic [1:0]    wen_q, wen_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic [15:0]   cnt_q, cnt_d;
    logic [7:0]    cnt_h_q, cnt_h_d;
    logic [AW-9:0] addr_h_q, addr_h_d;
    logic [2:0]    idx_q, idx_d;
    logic [25:0]   asm_q, asm_d;
    logic          accept;
`ifdef IM_LOADER_CKSUM_EN
    logic [7:0]    sum_q, sum_d;
`endif

    assign rx_ready_o_iml = (state_q != WRITE) && (state_q != DONE);
    assign accept         = rx_valid_i_iml && rx_ready_o_iml;

    always_comb begin
        state_d  = state_q;
        node_d   = node_q;
        opr0_d   = opr0_q;
        tf_d     = tf_q;
        busy_d   = busy_q;
        err_d    = err_q;
        cnt_d    = cnt_q;
        cnt_h_d  = cnt_h_q;
        addr_h_d = addr_h_q;
        idx_d    = idx_q;
        asm_d    = asm_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (rx_data_i_iml == HDR) begin
                        state_d = A_H;
                        err_d   = 1'b0;
                        busy_d  = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            A_H: begin
                if (accept) begin
                    addr_h_d = rx_data_i_iml[AW-9:0];
                    state_d  = A_L;
                end
            end
            A_L: begin
                if (accept) begin
                    node_d  = {addr_h_q, rx_data_i_iml};
                    state_d = C_H;
                end
            end
            C_H: begin
                if (accept) begin
                    cnt_h_d = rx_data_i_iml;
                    state_d = C_L;
                end
            end
            C_L: begin
                if (accept) begin
                    cnt_d   = {cnt_h_q, rx_data_i_iml};
                    idx_d   = 3'd0;
                    state_d = ({cnt_h_q, rx_data_i_iml} == 16'd0) ? END_ST : DATA;
                end
            end
            DATA: begin
                // Byte 0 carries only the tf/uni bits; bytes 1-4 are opr0 MSB first
                if (accept) begin
                    idx_d = idx_q + 3'd1;
                    case (idx_q)
                        3'd0: asm_d[25:24] = rx_data_i_iml[1:0];
                        3'd1: asm_d[23:16] = rx_data_i_iml;
                        3'd2: asm_d[15:8]  = rx_data_i_iml;
                        3'd3: asm_d[7:0]   = rx_data_i_iml;
                        default: begin
                            opr0_d  = {asm_q[23:0], rx_data_i_iml};
                            tf_d    = asm_q[25:24];
                            idx_d   = 3'd0;
                            state_d = WRITE;
                        end
                    endcase
                end
            end
            WRITE: begin
                node_d  = node_q + AW'(1);
                cnt_d   = cnt_q - 16'd1;
                state_d = (cnt_q == 16'd1) ? END_ST : DATA;
            end
`ifdef IM_LOADER_CKSUM_EN
            CKS: begin
                if (accept) begin
                    if (8'(sum_q + rx_data_i_iml) != 8'h00) err_d = 1'b1;
                    state_d = DONE;
                end
            end
`endif
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Write strobe and done pulse are registered copies of the state being entered
        wen_d  = (state_d == WRITE) ? 2'b11 : 2'b00;
        done_d = (state_d == DONE);
        if (state_d == DONE) busy_d = 1'b0;
    end

`ifdef IM_LOADER_CKSUM_EN
    always_comb begin
        sum_d = sum_q;
        if (accept) begin
            if (state_q == IDLE) sum_d = 8'h00;
            else if (state_q != CKS) sum_d = sum_q + rx_data_i_iml;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) sum_q <= 8'h00;
        else      sum_q <= sum_d;
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            node_q   <= '0;
            opr0_q   <= '0;
            tf_q     <= '0;
            wen_q    <= 2'b00;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
            cnt_h_q  <= '0;
            addr_h_q <= '0;
            idx_q    <= '0;
            asm_q    <= '0;
        end else begin
            state_q  <= state_d;
            node_q   <= node_d;
            opr0_q   <= opr0_d;
            tf_q     <= tf_d;
            wen_q    <= wen_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
            cnt_h_q  <= cnt_h_d;
            addr_h_q <= addr_h_d;
            idx_q    <= idx_d;
            asm_q    <= asm_d;
        end
    end

    assign node_o_iml       = node_q;
    assign opr0_o_iml       = opr0_q;
    assign tf_uni_opr_o_iml = tf_q;
    assign mem_wen_o_iml    = wen_q;
    assign busy_o_iml       = busy_q;
    assign done_o_iml       = done_q;
    assign err_o_iml        = err_q;

endmodule

// File: tb/tb_im_loader.sv
// Self-checking bench for im_loader: a frame-level model predicts the IM writes
// and done pulses; literal checks pin addresses, data, timing and reset.
module tb_im_loader;
    localparam int AW = 14;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    rx_data = 8'h00;
    logic          rx_valid = 1'b0;
    logic          rx_ready;
    logic [AW-1:0] node;
    logic [31:0]   opr0;
    logic [1:0]    tf;
    logic [1:0]    wen;
    logic          busy;
    logic          done;
    logic          err;

    im_loader #(.AW(AW), .HDR(8'hA5)) dut (
        .clk              (clk),
        .rst              (rst),
        .rx_data_i_iml    (rx_data),
        .rx_valid_i_iml   (rx_valid),
        .rx_ready_o_iml   (rx_ready),
        .node_o_iml       (node),
        .opr0_o_iml       (opr0),
        .tf_uni_opr_o_iml (tf),
        .mem_wen_o_iml    (wen),
        .busy_o_iml       (busy),
        .done_o_iml       (done),
        .err_o_iml        (err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] node;
        logic [1:0]    tf;
        logic [31:0]   op;
    } wr_t;

    int            total = 0;
    int            bad = 0;
    int            cyc = 0;
    wr_t           exp_q[$];
    int            exp_done = 0;
    logic [AW-1:0] obs_node[$];
    logic [31:0]   last_op = '0;
    logic [1:0]    last_tf = '0;
    int            wr_cyc = 0;
    int            done_cyc = 0;
    int            wr_count = 0;
    int            last_acc_cyc = 0;
    int            w5_cyc = 0;
    logic [7:0]    fsum = 8'h00;
    logic          rnd_hi = 1'b0;
    logic [1:0]    wtf[8];
    logic [31:0]   wop[8];
    logic          prev_acc = 1'b0;
    logic          prev_wen = 1'b0;
`ifdef IM_LOADER_CKSUM_EN
    logic          cks_bad = 1'b0;
`endif

    always @(posedge clk) cyc <= cyc + 1;

    task automatic fail_now(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        bad++;
        $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        if (act !== req) fail_now(name, act, req);
        else total++;
    endtask

    // Per-cycle compare against the frame-level model
    always @(negedge clk) begin
        if (rst) begin
            if (wen == 2'b11) begin
                wr_count++;
                wr_cyc = cyc;
                obs_node.push_back(node);
                last_op = opr0;
                last_tf = tf;
                check("wen_after_5th_byte", prev_acc, 1);
                check("ready_low_in_write", rx_ready, 0);
                check("busy_in_write", busy, 1);
                check("write_one_cycle", prev_wen, 0);
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_write", node, 0);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    check("write_node", node, e.node);
                    check("write_tf", tf, e.tf);
                    check("write_opr0", opr0, e.op);
                end
            end else if (wen != 2'b00) begin
                fail_now("wen_encoding", wen, 0);
            end
            if (done) begin
                done_cyc = cyc;
                check("ready_low_in_done", rx_ready, 0);
                check("busy_low_in_done", busy, 0);
                check("done_after_byte_or_write", prev_acc | prev_wen, 1);
                if (exp_done == 0) fail_now("unexpected_done", done, 0);
                else exp_done--;
            end
            prev_acc = rx_valid && rx_ready;
            prev_wen = (wen == 2'b11);
        end else begin
            prev_acc = 1'b0;
            prev_wen = 1'b0;
        end
    end

    task automatic gap(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int k;
        k = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        while (!rx_ready) begin
            k++;
            if (k > 40) begin
                fail_now("byte_accept_timeout", b, 0);
                rx_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        last_acc_cyc = cyc;
        @(posedge clk);
        #2;
        rx_valid = 1'b0;
    endtask

    task automatic sb(input logic [7:0] b, input int gmax);
        send_byte(b);
        fsum = fsum + b;
        if (gmax > 0) gap($urandom_range(0, gmax));
    endtask

    // Queue the expected writes, then stream the whole frame
    task automatic send_frame(input logic [15:0] addr, input int n, input int gmax);
        logic [AW-1:0] nd;
        logic [15:0]   cnt;
        cnt = 16'(n);
        nd  = addr[AW-1:0];
        for (int i = 0; i < n; i++) begin
            exp_q.push_back('{node: nd, tf: wtf[i], op: wop[i]});
            nd = nd + 1'b1;
        end
        exp_done++;
        send_byte(8'hA5);
        fsum = 8'h00;
        sb(addr[15:8], gmax);
        sb(addr[7:0], gmax);
        sb(cnt[15:8], gmax);
        sb(cnt[7:0], gmax);
        for (int i = 0; i < n; i++) begin
            sb({(rnd_hi ? 6'($urandom_range(0, 63)) : 6'd0), wtf[i]}, gmax);
            sb(wop[i][31:24], gmax);
            sb(wop[i][23:16], gmax);
            sb(wop[i][15:8], gmax);
            send_byte(wop[i][7:0]);
            w5_cyc = last_acc_cyc;
            fsum = fsum + wop[i][7:0];
            if (gmax > 0) gap($urandom_range(0, gmax));
        end
`ifdef IM_LOADER_CKSUM_EN
        send_byte(8'(8'h00 - fsum) + {7'd0, cks_bad});
`endif
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_node"}, node, 0);
        check({tag, "_opr0"}, opr0, 0);
        check({tag, "_tf"}, tf, 0);
        check({tag, "_wen"}, wen, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_ready"}, rx_ready, 1);
    endtask

    initial begin
        int wc;
        #3 rst = 1'b0;
        #9 check_reset_vals("reset");
        @(posedge clk);
        #2 rst = 1'b1;
        gap(2);

        // Single word at 0x0010, pinned literals
        wtf[0] = 2'b10;
        wop[0] = 32'hDEADBEEF;
        obs_node.delete();
        send_frame(16'h0010, 1, 0);
        gap(4);
        check("A_node", obs_node.size() > 0 ? obs_node[0] : 14'h3FFF, 14'h0010);
        check("A_opr0", last_op, 32'hDEADBEEF);
        check("A_tf", last_tf, 2'b10);
        check("A_write_latency", wr_cyc - w5_cyc, 1);
`ifdef IM_LOADER_CKSUM_EN
        check("A_done_latency", done_cyc - last_acc_cyc, 1);
`else
        check("A_done_latency", done_cyc - wr_cyc, 1);
`endif
        check("A_err", err, 0);
        check("A_busy_end", busy, 0);

        // Three words across the address wrap, with stalls
        wtf[0] = 2'b01; wop[0] = 32'h01234567;
        wtf[1] = 2'b11; wop[1] = 32'h89ABCDEF;
        wtf[2] = 2'b00; wop[2] = 32'hFFFF0000;
        rnd_hi = 1'b1;
        obs_node.delete();
        send_frame(16'hFFFF, 3, 2);
        gap(4);
        check("B_writes", obs_node.size(), 3);
        if (obs_node.size() == 3) begin
            check("B_node0", obs_node[0], 14'h3FFF);
            check("B_node1", obs_node[1], 14'h0000);
            check("B_node2", obs_node[2], 14'h0001);
        end

        // Bad leading byte, then a clean frame
        wc = wr_count;
        send_byte(8'h5A);
        gap(3);
        check("C_err_set", err, 1);
        check("C_no_write", wr_count, wc);
        check("C_not_busy", busy, 0);
        wtf[0] = 2'b11; wop[0] = 32'hCAFEF00D;
        send_frame(16'h0200, 1, 1);
        gap(4);
        check("C_err_cleared", err, 0);
        check("C_one_write", wr_count, wc + 1);

        // Empty frame
        wc = wr_count;
        send_frame(16'h0123, 0, 0);
        gap(4);
        check("D_no_write", wr_count, wc);
        check("D_done_latency", done_cyc - last_acc_cyc, 1);

        // Reset mid-word after three word bytes
        wc = wr_count;
        send_byte(8'hA5);
        send_byte(8'h00); gap($urandom_range(0, 3));
        send_byte(8'h20); gap($urandom_range(0, 3));
        send_byte(8'h00); gap($urandom_range(0, 3));
        send_byte(8'h01); gap($urandom_range(0, 3));
        send_byte(8'h03); gap($urandom_range(0, 3));
        send_byte(8'h11); gap($urandom_range(0, 3));
        send_byte(8'h22);
        gap(1);
        check("E_busy_before_reset", busy, 1);
        check("E_node_before_reset", node, 14'h0020);
        #1 rst = 1'b0;
        #1 check_reset_vals("E_async");
        gap(2);
        rst = 1'b1;
        gap(3);
        check("E_no_write", wr_count, wc);

        // Clean frame after reset
        wtf[0] = 2'b10; wop[0] = 32'h13579BDF;
        wtf[1] = 2'b01; wop[1] = 32'h2468ACE0;
        send_frame(16'h1FFE, 2, 3);
        gap(4);
        check("F_err", err, 0);

`ifdef IM_LOADER_CKSUM_EN
        // Good then corrupted checksum
        wtf[0] = 2'b01; wop[0] = 32'h55AA55AA;
        cks_bad = 1'b0;
        send_frame(16'h0040, 1, 1);
        gap(4);
        check("G_cks_ok_err", err, 0);
        wtf[0] = 2'b10; wop[0] = 32'h0BADF00D;
        cks_bad = 1'b1;
        send_frame(16'h0041, 1, 1);
        gap(4);
        check("G_cks_bad_err", err, 1);
        check("G_cks_bad_done", done_cyc - last_acc_cyc, 1);
        cks_bad = 1'b0;
`endif

        gap(4);
        check("end_writes_drained", exp_q.size(), 0);
        check("end_dones_drained", exp_done, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        fail_now("global_timeout", cyc, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] timeout");
    end

endmodule
